// File: rtl/cordic_vectoring.sv
// -----------------------------------------------------------------------------
// cordic_vectoring
//
// Iterative CORDIC engine in vectoring mode: takes a signed 2.19 fixed-point
// vector (x, y) and returns atan2(y, x) in radians (signed 3.19, range
// (-pi, +pi]) together with the vector magnitude (signed 4.19, always >= 0).
// One micro-rotation is performed per clock. Both sides use a valid/ready
// handshake, and only one operation is in flight at a time.
//
// Optional feature (compile-time macro CORDIC_GAIN_COMP_EN):
//   defined   - an extra SCALE cycle multiplies the final x by 1/K, so mag_out
//               is the true magnitude |v|.
//   undefined - no multiplier; mag_out is the raw CORDIC x (about 1.64676*|v|).
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-low reset
//   in_valid   in   x_in / y_in hold a valid operand
//   in_ready   out  engine is idle and can accept an operand
//   x_in       in   signed 2.19 x component  [WORD_LENGTH]
//   y_in       in   signed 2.19 y component  [WORD_LENGTH]
//   out_valid  out  angle_out / mag_out hold a result
//   out_ready  in   consumer takes the result
//   angle_out  out  signed 3.19 atan2(y, x)  [WORD_LENGTH+1]
//   mag_out    out  signed 4.19 magnitude    [WORD_LENGTH+2]
// -----------------------------------------------------------------------------
module cordic_vectoring #(
    parameter int WORD_LENGTH  = 21,
    parameter int N_ITERATIONS = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] x_in,
    input  logic [WORD_LENGTH-1:0] y_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH:0]   angle_out,
    output logic [WORD_LENGTH+1:0] mag_out
);

    // Internal width: two guard bits above the input format keep the CORDIC
    // growth (|v| * 1.647 < 4.66) and +/-pi inside range without saturation.
    localparam int IW = WORD_LENGTH + 2;

    localparam logic signed [IW-1:0] PI_2 = IW'(823550);

    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        ITER,
`ifdef CORDIC_GAIN_COMP_EN
        SCALE,
`endif
        DONE
    } state_t;

    // atan(2^-i) in 19 fraction bits.
    function automatic logic signed [IW-1:0] alpha(input logic [4:0] idx);
        case (idx)
            5'd0:    alpha = IW'(411775);
            5'd1:    alpha = IW'(243085);
            5'd2:    alpha = IW'(128439);
            5'd3:    alpha = IW'(65198);
            5'd4:    alpha = IW'(32725);
            5'd5:    alpha = IW'(16379);
            5'd6:    alpha = IW'(8191);
            5'd7:    alpha = IW'(4096);
            5'd8:    alpha = IW'(2048);
            5'd9:    alpha = IW'(1024);
            5'd10:   alpha = IW'(512);
            5'd11:   alpha = IW'(256);
            5'd12:   alpha = IW'(128);
            5'd13:   alpha = IW'(64);
            5'd14:   alpha = IW'(32);
            5'd15:   alpha = IW'(16);
            5'd16:   alpha = IW'(8);
            default: alpha = '0;
        endcase
    endfunction

    state_t                 state_q;
    logic signed [IW-1:0]   x_q, y_q, z_q;
    logic [4:0]             iter_q;
    logic                   in_ready_q, out_valid_q;
    logic [WORD_LENGTH:0]   angle_q;
    logic [IW-1:0]          mag_q;

    logic signed [IW-1:0]   x_sh, y_sh;
    logic signed [IW-1:0]   x_d, y_d, z_d;
    logic                   last_iter;

    assign last_iter = (iter_q == 5'(N_ITERATIONS - 1));

    // One micro-rotation driving y toward zero; every update uses the old x/y.
    // NOTE: each output gets a default at the top so no path leaves a latch.
    always_comb begin
        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        if (!y_q[IW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + alpha(iter_q);
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - alpha(iter_q);
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // Gain compensation: x * (1/K) with 1/K = 318375 / 2^19, product kept at
    // full width and then truncated back to the internal width.
    localparam int PW = IW + 21;
    localparam logic signed [PW-1:0] INV_K = PW'(318375);

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] scale_prod;
    logic signed [IW-1:0] x_scaled;

    assign x_ext      = {{(PW-IW){x_q[IW-1]}}, x_q};
    assign scale_prod = x_ext * INV_K;
    assign x_scaled   = scale_prod[IW+18:19];
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
            // NOTE: x/y/z/iter are always loaded before they are used, so
            // they are deliberately left out of reset.
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= {{2{x_in[WORD_LENGTH-1]}}, x_in};
                        y_q        <= {{2{y_in[WORD_LENGTH-1]}}, y_in};
                        z_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= FOLD;
                    end
                end

                FOLD: begin
                    iter_q <= '0;
                    if (x_q == '0 && y_q == '0) begin
                        // Zero vector: the rotations would leave z at the sum
                        // of all alphas, so report 0 directly.
                        z_q <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                        state_q <= SCALE;
`else
                        angle_q     <= '0;
                        mag_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end else begin
                        // Left half-plane: pre-rotate by +/-90 deg so the
                        // iterations only need to cover (-pi/2, pi/2).
                        // y == 0 folds upward, so the result is +pi, not -pi.
                        if (x_q[IW-1] && !y_q[IW-1]) begin
                            x_q <= y_q;
                            y_q <= -x_q;
                            z_q <= PI_2;
                        end else if (x_q[IW-1] && y_q[IW-1]) begin
                            x_q <= -y_q;
                            y_q <= x_q;
                            z_q <= -PI_2;
                        end
                        state_q <= ITER;
                    end
                end

                ITER: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    iter_q <= iter_q + 5'd1;
                    if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_q <= SCALE;
`else
                        angle_q     <= z_d[WORD_LENGTH:0];
                        mag_q       <= x_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end
                end

`ifdef CORDIC_GAIN_COMP_EN
                SCALE: begin
                    x_q         <= x_scaled;
                    angle_q     <= z_q[WORD_LENGTH:0];
                    mag_q       <= x_scaled;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
`endif

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// -----------------------------------------------------------------------------
// tb_cordic_vectoring
//
// Self-checking bench for cordic_vectoring. Expected angles and magnitudes come
// from real-valued atan2 / sqrt scaled to 19 fraction bits, with the CORDIC
// gain applied when the gain-compensation macro is not defined.
// -----------------------------------------------------------------------------
module tb_cordic_vectoring;

    localparam int WL  = 21;
    localparam int TOL = 16;
    localparam real ONE = 524288.0;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = 19;
    localparam bit COMP = 1'b1;
`else
    localparam int LAT  = 18;
    localparam bit COMP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WL-1:0] x_in = '0;
    logic [WL-1:0] y_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WL:0]   angle_out;
    logic [WL+1:0] mag_out;

    int  total = 0;
    int  bad   = 0;
    real gain  = 1.0;

    cordic_vectoring #(
        .WORD_LENGTH (WL),
        .N_ITERATIONS(17)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .angle_out(angle_out),
        .mag_out  (mag_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_angle(input int x, input int y);
        return int'($atan2(real'(y), real'(x)) * ONE);
    endfunction

    function automatic int ref_mag(input int x, input int y);
        real m;
        m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        if (!COMP) m = m * gain;
        return int'(m);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // ---------------- drivers ----------------
    // Full transaction: present operand, wait for acceptance, count edges to
    // out_valid, capture the result and consume it.
    task automatic run_op(input int x, input int y, output int ang, output int mag,
                          output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        ang = 0;
        mag = 0;
        lat = 0;
        @(negedge clk);
        x_in     = WL'(x);
        y_in     = WL'(y);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        ang = $signed(angle_out);
        mag = $signed(mag_out);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (angle_out !== '0) begin bad++; $display("FAIL reset_angle got=%0d want=0", $signed(angle_out)); end
        total++; if (mag_out !== '0) begin bad++; $display("FAIL reset_mag got=%0d want=0", $signed(mag_out)); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int xs [5] = '{524288, 262144, -262144, 0, -393216};
        int ys [5] = '{0, 262144, 0, -262144, -131072};
        int ang, mag, lat, ea, em;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], ys[i], ang, mag, lat, ok);
            ea = ref_angle(xs[i], ys[i]);
            em = ref_mag(xs[i], ys[i]);
            total++;
            if (!ok) begin
                bad++; $display("FAIL directed[%0d]_timeout got=timeout want=result", i);
            end else begin
                total++; if (iabs(ang - ea) > TOL) begin bad++; $display("FAIL directed[%0d]_angle got=%0d want=%0d+-%0d", i, ang, ea, TOL); end
                total++; if (iabs(mag - em) > TOL) begin bad++; $display("FAIL directed[%0d]_mag got=%0d want=%0d+-%0d", i, mag, em, TOL); end
                total++; if (lat != LAT) begin bad++; $display("FAIL directed[%0d]_latency got=%0d want=%0d", i, lat, LAT); end
            end
            // (-0.5, 0) must land on +pi, never -pi.
            if (i == 2) begin
                total++; if (ang <= 0) begin bad++; $display("FAIL neg_x_angle_sign got=%0d want>0", ang); end
            end
        end
    endtask

    task automatic test_zero();
        int ang, mag, lat;
        bit ok;
        run_op(0, 0, ang, mag, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout got=timeout want=result"); end
        total++; if (ang != 0) begin bad++; $display("FAIL zero_angle got=%0d want=0", ang); end
        total++; if (mag != 0) begin bad++; $display("FAIL zero_mag got=%0d want=0", mag); end
    endtask

    task automatic test_backpressure();
        int n, a0, m0, ang, mag, lat, ea, em;
        bit ok, good;
        @(negedge clk);
        x_in = WL'(262144); y_in = WL'(262144); in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        total++;
        if (!out_valid) begin
            bad++; $display("FAIL bp_timeout got=timeout want=out_valid");
        end else begin
            a0 = $signed(angle_out);
            m0 = $signed(mag_out);
            total++; if (iabs(a0 - 411775) > TOL) begin bad++; $display("FAIL bp_angle got=%0d want=411775+-%0d", a0, TOL); end
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                good = (out_valid === 1'b1) && (in_ready === 1'b0) &&
                       ($signed(angle_out) == a0) && ($signed(mag_out) == m0);
                total++;
                if (!good) begin
                    bad++; $display("FAIL bp_hold[%0d] got=v%b r%b a%0d m%0d want=v1 r0 a%0d m%0d",
                                    k, out_valid, in_ready, $signed(angle_out), $signed(mag_out), a0, m0);
                end
                // Stray operand while stalled: must be ignored.
                if (k == 3) begin
                    x_in = WL'(-262144); y_in = WL'(0); in_valid = 1'b1;
                end
                if (k == 5) in_valid = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%b r%b want=v0 r1", out_valid, in_ready); end
            repeat (4) @(negedge clk);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_stray_accepted got=v%b r%b want=v0 r1", out_valid, in_ready); end
        end
        run_op(131072, -393216, ang, mag, lat, ok);
        ea = ref_angle(131072, -393216);
        em = ref_mag(131072, -393216);
        total++; if (!ok) begin bad++; $display("FAIL bp_next_timeout got=timeout want=result"); end
        total++; if (iabs(ang - ea) > TOL) begin bad++; $display("FAIL bp_next_angle got=%0d want=%0d+-%0d", ang, ea, TOL); end
        total++; if (iabs(mag - em) > TOL) begin bad++; $display("FAIL bp_next_mag got=%0d want=%0d+-%0d", mag, em, TOL); end
    endtask

    task automatic test_reset_mid();
        int n, ang, mag, lat, ea, em;
        bit ok;
        @(negedge clk);
        x_in = WL'(157286); y_in = WL'(-367001); in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        // One edge for FOLD, then iterations 0..7; the next edge would run i=8.
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        total++; if (angle_out !== '0 || mag_out !== '0) begin bad++; $display("FAIL midrst_outputs got=a%0d m%0d want=a0 m0", $signed(angle_out), $signed(mag_out)); end
        repeat (20) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_lost got=%b want=0", out_valid); end
        run_op(262144, 262144, ang, mag, lat, ok);
        ea = 411775;
        em = ref_mag(262144, 262144);
        total++; if (!ok) begin bad++; $display("FAIL midrst_next_timeout got=timeout want=result"); end
        total++; if (iabs(ang - ea) > TOL) begin bad++; $display("FAIL midrst_next_angle got=%0d want=%0d+-%0d", ang, ea, TOL); end
        total++; if (iabs(mag - em) > TOL) begin bad++; $display("FAIL midrst_next_mag got=%0d want=%0d+-%0d", mag, em, TOL); end
        total++; if (lat != LAT) begin bad++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, LAT); end
    endtask

    task automatic test_random();
        int x, y, ang, mag, lat, ea, em;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            // Keep vectors away from the origin, where the angle is ill-defined.
            do begin
                x = int'($urandom_range(0, 2097151)) - 1048576;
                y = int'($urandom_range(0, 2097151)) - 1048576;
            end while (iabs(x) < 131072 && iabs(y) < 131072);
            run_op(x, y, ang, mag, lat, ok);
            ea = ref_angle(x, y);
            em = ref_mag(x, y);
            total++;
            if (!ok) begin
                bad++; $display("FAIL rand[%0d]_timeout x=%0d y=%0d got=timeout want=result", i, x, y);
            end else begin
                total++; if (iabs(ang - ea) > TOL) begin bad++; $display("FAIL rand[%0d]_angle x=%0d y=%0d got=%0d want=%0d+-%0d", i, x, y, ang, ea, TOL); end
                total++; if (iabs(mag - em) > TOL) begin bad++; $display("FAIL rand[%0d]_mag x=%0d y=%0d got=%0d want=%0d+-%0d", i, x, y, mag, em, TOL); end
                total++; if (lat != LAT) begin bad++; $display("FAIL rand[%0d]_latency got=%0d want=%0d", i, lat, LAT); end
            end
        end
    endtask

    initial begin
        // CORDIC gain of 17 micro-rotations: prod sqrt(1 + 2^-2i).
        for (int i = 0; i < 17; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        test_reset();
        test_directed();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
